// File: rtl/regdump_pkg.sv
// Shared types and constants for the register-file dump controller.
package regdump_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SEND  = 3'd2,
    S_CHK   = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam int         DATA_W_DEFAULT = 32;
  localparam int         BYTES_PER_WORD = DATA_W_DEFAULT / 8;
  localparam logic [7:0] CHK_INIT       = 8'h00;

  function automatic int bytes_per_word(input int w);
    return w / 8;
  endfunction

endpackage

// File: rtl/regfile_dump_ctrl_serializer.sv
// word_byte_serializer: loads a word and shifts it out LSB-first over valid/ready.
// one_i loads a single-byte frame (only the low byte is sent, flagged last).
module word_byte_serializer
  import regdump_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              one_i,
  input  logic [DATA_W-1:0] word_i,
  input  logic              ready_i,
  output logic [7:0]        byte_o,
  output logic              valid_o,
  output logic              last_o,
  output logic              accept_o
);

  localparam int BPW = bytes_per_word(DATA_W);
  localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [DATA_W-1:0] shift_q;
  logic [IW-1:0]     idx_q;
  logic              valid_q;

  assign byte_o   = shift_q[7:0];
  assign valid_o  = valid_q;
  assign last_o   = (idx_q == IW'(BPW - 1));
  assign accept_o = valid_q & ready_i;

  // A load on the same edge as the final accept keeps valid high (back-to-back frames).
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      shift_q <= word_i;
      idx_q   <= one_i ? IW'(BPW - 1) : '0;
      valid_q <= 1'b1;
    end else if (accept_o) begin
      if (last_o) begin
        valid_q <= 1'b0;
      end else begin
        shift_q <= shift_q >> 8;
        idx_q   <= idx_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_dump_ctrl.sv
// Dumps registers 0..NREGS-1 through the ID-stage debug read port as a byte stream.
// Define REGDUMP_CHECKSUM_EN to append an XOR checksum byte after the last register.
module regfile_dump_ctrl
  import regdump_pkg::*;
#(
  parameter int NREGS  = 32,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] du_areg,
  output logic              du_c1,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  state_e            state_q;
  logic [ADDR_W-1:0] du_areg_q;
  logic              du_c1_q, busy_q, done_q;

  logic              ser_ld, ser_one, ser_acc, ser_last;
  logic [DATA_W-1:0] ser_word;
  logic              last_reg;

  assign last_reg = (du_areg_q == ADDR_W'(NREGS - 1));
  assign du_areg  = du_areg_q;
  assign du_c1    = du_c1_q;
  assign busy     = busy_q;
  assign done     = done_q;

`ifdef REGDUMP_CHECKSUM_EN
  logic [7:0] acc_q;

  // The checksum byte is loaded on the final data accept, so fold that byte in here.
  always_comb begin
    ser_ld   = (state_q == S_SETUP);
    ser_one  = 1'b0;
    ser_word = rd_data;
    if (state_q == S_SEND && ser_acc && ser_last && last_reg) begin
      ser_ld        = 1'b1;
      ser_one       = 1'b1;
      ser_word      = '0;
      ser_word[7:0] = acc_q ^ tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      acc_q <= CHK_INIT;
    else if (state_q == S_IDLE && start)
      acc_q <= CHK_INIT;
    else if (ser_acc)
      acc_q <= acc_q ^ tx_data;
  end
`else
  assign ser_ld   = (state_q == S_SETUP);
  assign ser_one  = 1'b0;
  assign ser_word = rd_data;
`endif

  word_byte_serializer #(.DATA_W(DATA_W)) u_ser (
    .clk      (clk),
    .reset    (reset),
    .load_i   (ser_ld),
    .one_i    (ser_one),
    .word_i   (ser_word),
    .ready_i  (tx_ready),
    .byte_o   (tx_data),
    .valid_o  (tx_valid),
    .last_o   (ser_last),
    .accept_o (ser_acc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      du_areg_q <= '0;
      du_c1_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          du_areg_q <= '0;
          du_c1_q   <= 1'b1;
          busy_q    <= 1'b1;
          state_q   <= S_SETUP;
        end
        S_SETUP: state_q <= S_SEND;
        S_SEND: if (ser_acc && ser_last) begin
          if (last_reg) begin
`ifdef REGDUMP_CHECKSUM_EN
            state_q <= S_CHK;
`else
            state_q <= S_DONE;
`endif
          end else begin
            du_areg_q <= du_areg_q + 1'b1;
            state_q   <= S_SETUP;
          end
        end
        S_CHK: if (ser_acc) state_q <= S_DONE;
        S_DONE: begin
          done_q    <= 1'b1;
          du_c1_q   <= 1'b0;
          busy_q    <= 1'b0;
          du_areg_q <= '0;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
